cart_backup_ctrl: RTL

//  Moves cartridge save RAM between the SD image and the cart RAM backup port, one 512-byte sector at a time.

---
 rtl/gb_pkg.sv | 25 ++
 rtl/bk_autosave_timer.sv | 38 +++
 rtl/cart_backup_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/gb_pkg.sv
// rtl/gb_pkg.sv - shared types and constants for the cart backup controller
//
// Purpose: FSM state encoding, transfer direction and sector geometry used by
//          cart_backup_ctrl.
// Ports:   none (package)

package gb_pkg;

    typedef enum logic [2:0] {
        BK_IDLE,
        BK_REQ,
        BK_ACKH,
        BK_ACKL,
        BK_DONE
    } bk_state_e;

    typedef enum logic {
        BK_OP_LOAD,
        BK_OP_SAVE
    } bk_op_e;

    // 16-bit words per 512-byte sector
    localparam int SECTOR_WORDS = 256;

endpackage

// File: rtl/bk_autosave_timer.sv
// rtl/bk_autosave_timer.sv - idle countdown that requests an automatic save
//
// Purpose: reloads on every cart RAM write. It counts down while enabled and
//          pulses expire_o on the cycle the count reaches zero, then reloads.
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous reset, active low
//   reload_i    restart the countdown (cart RAM write)
//   count_en_i  count this cycle (controller idle, RAM dirty, autosave enabled)
//   expire_o    one-cycle expiry pulse (combinational)

module bk_autosave_timer #(
    parameter logic [23:0] TICKS = 24'd8_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic reload_i,
    input  logic count_en_i,
    output logic expire_o
);

    logic [23:0] count_q;

    // A freshly reloaded count of TICKS expires after exactly TICKS enabled
    // cycles. A write in the same cycle restarts the count instead of firing.
    assign expire_o = count_en_i && !reload_i && (count_q <= 24'd1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (reload_i || expire_o) begin
            count_q <= TICKS;
        end else if (count_en_i) begin
            count_q <= count_q - 24'd1;
        end
    end

endmodule

// File: rtl/cart_backup_ctrl.sv
// rtl/cart_backup_ctrl.sv - sector-wise save RAM load/store between SD image and cart
//
// Purpose: loads cart save RAM from the SD image on mount. Stores it back on an
//          OSD request or on autosave. Tracks whether cart RAM is dirty.
// Ports:
//   clk_sys, reset_n                   clock, async active-low reset
//   has_save, ram_mask_file, cram_wr   cart side: battery RAM present, last sector, RAM write
//   img_mounted, img_readonly, img_size  image mount information
//   bk_save_req, autosave_en           save triggers
//   sd_lba, sd_rd, sd_wr, sd_ack       HPS sector request handshake
//   sd_buff_addr, sd_buff_dout, sd_buff_wr  HPS sector buffer stream
//   bk_addr, bk_data, bk_wr            cart RAM backup write port (combinational)
//   bk_busy, bk_loaded, bk_dirty       status

module cart_backup_ctrl
    import gb_pkg::*;
#(
    parameter logic [23:0] AUTOSAVE_TICKS = 24'd8_000_000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        has_save,
    input  logic [7:0]  ram_mask_file,
    input  logic        cram_wr,
    input  logic        img_mounted,
    input  logic        img_readonly,
    input  logic [63:0] img_size,
    input  logic        bk_save_req,
    input  logic        autosave_en,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [7:0]  sd_buff_addr,
    input  logic [15:0] sd_buff_dout,
    input  logic        sd_buff_wr,
    output logic [16:0] bk_addr,
    output logic [15:0] bk_data,
    output logic        bk_wr,
    output logic        bk_busy,
    output logic        bk_loaded,
    output logic        bk_dirty
);

    localparam int WORD_IDX_W = $clog2(SECTOR_WORDS);

    bk_state_e   state_q;
    bk_op_e      op_q;
    logic [31:0] sd_lba_q;
    logic        sd_rd_q;
    logic        sd_wr_q;
    logic        busy_q;
    logic        loaded_q;
    logic        dirty_q;
    logic        ro_q;
    logic        redirty_q;   // cart wrote RAM while an op was in flight
    logic        pend_q;      // mount seen while busy, serviced back in IDLE
    logic        pend_ro_q;
    logic        pend_ok_q;
    logic        save_req_q;

    logic save_edge;
    logic autosave_fire;
    logic mount_now;
    logic mount_ro;
    logic mount_ok;
    logic start_save;

    assign save_edge  = bk_save_req & ~save_req_q;
    // A live mount pulse takes precedence over a stale pending one.
    assign mount_now  = img_mounted | pend_q;
    assign mount_ro   = img_mounted ? img_readonly : pend_ro_q;
    assign mount_ok   = img_mounted ? (img_size != 64'd0) : pend_ok_q;
    // Triggers that fail the checks are dropped, not remembered.
    assign start_save = (save_edge | autosave_fire) & loaded_q & ~ro_q & dirty_q;

    bk_autosave_timer #(
        .TICKS (AUTOSAVE_TICKS)
    ) u_autosave (
        .clk_i      (clk_sys),
        .rst_ni     (reset_n),
        .reload_i   (cram_wr),
        .count_en_i ((state_q == BK_IDLE) & dirty_q & autosave_en),
        .expire_o   (autosave_fire)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= BK_IDLE;
            op_q       <= BK_OP_LOAD;
            sd_lba_q   <= '0;
            sd_rd_q    <= 1'b0;
            sd_wr_q    <= 1'b0;
            busy_q     <= 1'b0;
            loaded_q   <= 1'b0;
            dirty_q    <= 1'b0;
            ro_q       <= 1'b0;
            redirty_q  <= 1'b0;
            pend_q     <= 1'b0;
            pend_ro_q  <= 1'b0;
            pend_ok_q  <= 1'b0;
            save_req_q <= 1'b0;
        end else begin
            save_req_q <= bk_save_req;
            if (cram_wr) begin
                dirty_q <= 1'b1;
            end
            if (cram_wr && state_q != BK_IDLE) begin
                redirty_q <= 1'b1;
            end
            if (img_mounted && state_q != BK_IDLE) begin
                pend_q    <= 1'b1;
                pend_ro_q <= img_readonly;
                pend_ok_q <= (img_size != 64'd0);
            end

            case (state_q)
                BK_IDLE: begin
                    if (mount_now) begin
                        // Any mount invalidates the loaded contents, even if
                        // there is nothing to load from.
                        pend_q   <= 1'b0;
                        loaded_q <= 1'b0;
                        ro_q     <= mount_ro;
                        if (mount_ok && has_save) begin
                            op_q      <= BK_OP_LOAD;
                            sd_lba_q  <= '0;
                            sd_rd_q   <= 1'b1;
                            busy_q    <= 1'b1;
                            redirty_q <= 1'b0;
                            state_q   <= BK_REQ;
                        end
                    end else if (start_save) begin
                        op_q      <= BK_OP_SAVE;
                        sd_lba_q  <= '0;
                        sd_wr_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        redirty_q <= 1'b0;
                        state_q   <= BK_REQ;
                    end
                end
                BK_REQ: begin
                    if (sd_ack) begin
                        sd_rd_q <= 1'b0;
                        sd_wr_q <= 1'b0;
                        state_q <= BK_ACKH;
                    end
                end
                BK_ACKH: begin
                    if (!sd_ack) begin
                        state_q <= BK_ACKL;
                    end
                end
                BK_ACKL: begin
                    if (sd_lba_q[7:0] == ram_mask_file) begin
                        state_q <= BK_DONE;
                    end else begin
                        sd_lba_q <= sd_lba_q + 32'd1;
                        sd_rd_q  <= (op_q == BK_OP_LOAD);
                        sd_wr_q  <= (op_q == BK_OP_SAVE);
                        state_q  <= BK_REQ;
                    end
                end
                BK_DONE: begin
                    if (op_q == BK_OP_LOAD) begin
                        loaded_q <= 1'b1;
                    end
                    // A write in this very cycle also keeps the RAM dirty.
                    dirty_q <= redirty_q | cram_wr;
                    busy_q  <= 1'b0;
                    state_q <= BK_IDLE;
                end
                default: begin
                    sd_rd_q <= 1'b0;
                    sd_wr_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= BK_IDLE;
                end
            endcase
        end
    end

    assign sd_lba    = sd_lba_q;
    assign sd_rd     = sd_rd_q;
    assign sd_wr     = sd_wr_q;
    assign bk_busy   = busy_q;
    assign bk_loaded = loaded_q;
    assign bk_dirty  = dirty_q;

    assign bk_addr = {1'b0, sd_lba_q[7:0], sd_buff_addr[WORD_IDX_W-1:0]};
    assign bk_data = sd_buff_dout;
    assign bk_wr   = sd_buff_wr & sd_ack & busy_q & (op_q == BK_OP_LOAD);

endmodule
